// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states
// and HI/LO write-select values.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } mdOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

    function automatic logic opIsDiv(input mdOp_e op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic opIsSigned(input mdOp_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partHi,
    input  logic [WIDTH-1:0] partLo,
    input  logic [WIDTH-1:0] operand,
    input  logic             isDiv,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: partLo holds the not-yet-consumed multiplier bits.
        sum     = {1'b0, partHi} + (partLo[0] ? {1'b0, operand} : '0);
        // Divide: partHi is the running remainder, partLo shifts dividend out / quotient in.
        shifted = {partHi, partLo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        if (isDiv) begin
            if (!diff[WIDTH]) begin
                nextHi = diff[WIDTH-1:0];
                nextLo = {partLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {partLo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], partLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Iterative mult/div sequencer owning HI/LO. Optional macro MD_EARLY_OUT_EN lets
// divide-by-zero and multiply-by-zero skip the iteration loop.
import md_pkg::*;

module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           stateReg, stateNext;
    mdOp_e            op;
    logic [CW-1:0]    countReg;
    logic [WIDTH-1:0] hiReg, loReg, partHiReg, partLoReg, operandReg, srcAReg;
    logic             isDivReg, negLoReg, negHiReg, divZeroReg, doneReg;
    logic [WIDTH-1:0] stepHi, stepLo, magA, magB, fixHi, fixLo;
    logic [2*WIDTH-1:0] prod;
    logic             signA, signB, earlyOut, loadOps, hiloWrite, stepEn, commit;

    assign op    = mdOp_e'(md_op);
    assign signA = opIsSigned(op) & src_a[WIDTH-1];
    assign signB = opIsSigned(op) & src_b[WIDTH-1];
    assign magA  = signA ? -src_a : src_a;
    assign magB  = signB ? -src_b : src_b;

`ifdef MD_EARLY_OUT_EN
    assign earlyOut = opIsDiv(op) ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
`else
    assign earlyOut = 1'b0;
`endif

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .partHi  (partHiReg),
        .partLo  (partLoReg),
        .operand (operandReg),
        .isDiv   (isDivReg),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stateReg <= ST_IDLE;
        else      stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: if (start) stateNext = earlyOut ? ST_FIX : ST_RUN;
            ST_RUN:  if (countReg == LAST_STEP) stateNext = ST_FIX;
            ST_FIX:  stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = start | (stateReg != ST_IDLE);
        loadOps   = (stateReg == ST_IDLE) & start;
        hiloWrite = (stateReg == ST_IDLE) & hilo_we & ~start;
        stepEn    = (stateReg == ST_RUN);
        commit    = (stateReg == ST_FIX);
    end

    // Sign correction on the magnitude result; divide-by-zero bypasses it entirely.
    always_comb begin
        prod  = {partHiReg, partLoReg};
        fixHi = partHiReg;
        fixLo = partLoReg;
        if (!isDivReg) begin
            {fixHi, fixLo} = negLoReg ? -prod : prod;
        end else if (divZeroReg) begin
            fixHi = srcAReg;
            fixLo = '1;
        end else begin
            fixLo = negLoReg ? -partLoReg : partLoReg;
            fixHi = negHiReg ? -partHiReg : partHiReg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countReg   <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            partHiReg  <= '0;
            partLoReg  <= '0;
            operandReg <= '0;
            srcAReg    <= '0;
            isDivReg   <= 1'b0;
            negLoReg   <= 1'b0;
            negHiReg   <= 1'b0;
            divZeroReg <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (loadOps) begin
                // An early-out multiply has a zero product, so the partials start cleared.
                partHiReg  <= '0;
                partLoReg  <= (earlyOut && !opIsDiv(op)) ? '0 : (opIsDiv(op) ? magA : magB);
                operandReg <= opIsDiv(op) ? magB : magA;
                srcAReg    <= src_a;
                isDivReg   <= opIsDiv(op);
                negLoReg   <= signA ^ signB;
                negHiReg   <= opIsDiv(op) ? signA : (signA ^ signB);
                divZeroReg <= opIsDiv(op) && (src_b == '0);
                countReg   <= '0;
            end else if (stepEn) begin
                partHiReg <= stepHi;
                partLoReg <= stepLo;
                if (countReg != LAST_STEP) countReg <= countReg + CW'(1);
            end else if (commit) begin
                hiReg    <= fixHi;
                loReg    <= fixLo;
                doneReg  <= 1'b1;
                countReg <= '0;
            end else if (hiloWrite) begin
                if (hilo_sel == HILO_SEL_HI) hiReg <= src_a;
                else                         loReg <= src_a;
            end
        end
    end

    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized self-checking bench for md_sequencer against a 64-bit arithmetic
// reference model; honours MD_EARLY_OUT_EN for expected busy duration.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        hilo_we, hilo_sel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;

    md_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain wide arithmetic on the architectural rules.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        h = '0;
        l = '0;
        case (op)
            2'b00: begin p = ua * ub; {h, l} = p; end
            2'b01: begin p = longint'(sa * sb); {h, l} = p; end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (op == 2'b11) begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    p = ua / ub;
                    l = p[31:0];
                    p = ua % ub;
                    h = p[31:0];
                end
            end
        endcase
    endfunction

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int intrudeAt, input bit withWe);
        logic [31:0] expHi, expLo;
        int  cyc, doneCnt, expCyc;
        bit  held, early;
        model(op, a, b, expHi, expLo);
        early = op[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
`ifdef MD_EARLY_OUT_EN
        expCyc = early ? 1 : 33;
`else
        expCyc = 33;
`endif
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        hilo_we = withWe; hilo_sel = $urandom_range(0, 1);
        #1 checkVal("busy_on_start", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0; hilo_we = 1'b0;
        src_a = $urandom; src_b = $urandom;
        cyc = 0; doneCnt = 0; held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (!busy) break;
            cyc++;
            if (hi !== refHi || lo !== refLo) held = 1'b0;
            start   = (cyc == intrudeAt);
            hilo_we = (cyc == intrudeAt);
            md_op   = 2'($urandom);
        end
        start = 1'b0; hilo_we = 1'b0;
        @(negedge clk);
        if (done) doneCnt++;
        checkVal("hi", 64'(hi), 64'(expHi));
        checkVal("lo", 64'(lo), 64'(expLo));
        checkVal("busy_cycles", 64'(cyc), 64'(expCyc));
        checkVal("done_pulses", 64'(doneCnt), 64'd1);
        checkVal("hilo_held", 64'(held), 64'd1);
        refHi = expHi;
        refLo = expLo;
        $display("md op=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d", op, a, b, hi, lo, cyc);
    endtask

    task automatic writeHilo(input logic sel, input logic [31:0] v);
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b1; hilo_sel = sel; src_a = v;
        @(posedge clk);
        #1 hilo_we = 1'b0;
        if (sel) refHi = v;
        else     refLo = v;
        checkVal(sel ? "mthi" : "mtlo", 64'(sel ? hi : lo), 64'(v));
        checkVal(sel ? "mthi_lo_kept" : "mtlo_hi_kept", 64'(sel ? lo : hi), 64'(sel ? refLo : refHi));
        $display("hilo write sel=%0d val=%08h -> hi=%08h lo=%08h", sel, v, hi, lo);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; md_op = 2'b00; src_a = '0; src_b = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("reset_busy", 64'(busy), 64'd0);
        checkVal("reset_done", 64'(done), 64'd0);
        checkVal("reset_hi", 64'(hi), 64'd0);
        checkVal("reset_lo", 64'(lo), 64'd0);
        rst = 1'b1;

        runOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        checkVal("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
        checkVal("multu_lo_const", 64'(lo), 64'h0000_0001);
        runOp(2'b01, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
        runOp(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        checkVal("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        checkVal("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        runOp(2'b10, 32'd5, 32'd0, -1, 1'b0);
        runOp(2'b11, 32'hFFFF_FFF0, 32'd0, -1, 1'b0);
        runOp(2'b01, 32'd0, 32'h1234_5678, -1, 1'b0);
        writeHilo(1'b1, 32'h1234_5678);
        writeHilo(1'b0, 32'hCAFE_F00D);
        runOp(2'b10, 32'd1000, 32'd7, 5, 1'b0);
        runOp(2'b01, 32'h0001_0003, 32'hFFFF_0005, -1, 1'b1);

        // Reset mid-multiply: outputs clear without waiting for a clock edge.
        @(negedge clk);
        start = 1'b1; md_op = 2'b01; src_a = 32'h0000_0123; src_b = 32'h0000_0456;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkVal("midop_reset_busy", 64'(busy), 64'd0);
        checkVal("midop_reset_hi", 64'(hi), 64'd0);
        checkVal("midop_reset_lo", 64'(lo), 64'd0);
        refHi = '0; refLo = '0;
        @(negedge clk);
        rst = 1'b1;
        runOp(2'b00, 32'd6, 32'd9, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0)
                writeHilo(1'($urandom_range(0, 1)), $urandom);
            runOp(2'($urandom), pickOperand(), pickOperand(),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 20)) : -1,
                  1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
